// File: rtl/muldiv_unit.sv
// ----------------------------------------------------------------------------
// muldiv_unit
//   Iterative multiply/divide unit with HI/LO registers. It sits beside the
//   EX-stage ALU and runs mult/multu/div/divu in WIDTH cycles, one radix-2
//   step per cycle. mthi/mtlo write HI/LO directly while the unit is idle.
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous, active-high reset
//   start      launch op (honoured only in IDLE, and not together with flush)
//   op         00 mult, 01 multu, 10 div, 11 divu
//   a, b       rs / rt operands
//   flush      abort an in-flight op (RUN only)
//   hi_we      mthi: HI <= wdata (IDLE only)
//   lo_we      mtlo: LO <= wdata (IDLE only)
//   wdata      mthi/mtlo data
//   busy       registered; high from the cycle after start through DONE
//   done       one-cycle pulse, HI/LO hold the new result in that cycle
//   hi, lo     HI / LO registers
//   state_dbg  current FSM state (IDLE=0, RUN=1, DONE=2)
//
// Handshake: start is a single-cycle request sampled in IDLE. While busy is
// high the pipeline holds off any dependent instruction, so no back-pressure
// signal exists; done marks the cycle the result becomes visible on hi/lo.
// ----------------------------------------------------------------------------
module muldiv_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             flush,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic [1:0]       state_dbg
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  // rem_q/quo_q form a 2*WIDTH shift register: for multiply it holds
  // {partial product, remaining multiplier bits}; for divide it holds
  // {partial remainder, dividend bits shifting into quotient bits}.
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] opb_q, opb_d;   // |multiplicand| or |divisor|
  logic             is_div_q, is_div_d;
  logic             neg_q, neg_d;   // product / quotient must be negated
  logic             rneg_q, rneg_d; // remainder must be negated
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  // Operand decode for a new op
  logic             st_signed, st_div, a_neg, b_neg, b_zero;
  logic [WIDTH-1:0] abs_a, abs_b;

  assign st_signed = ~op[0];
  assign st_div    = op[1];
  assign a_neg     = st_signed & a[WIDTH-1];
  assign b_neg     = st_signed & b[WIDTH-1];
  assign abs_a     = a_neg ? (~a + 1'b1) : a;
  assign abs_b     = b_neg ? (~b + 1'b1) : b;
  assign b_zero    = (b == '0);

  // One iteration step
  logic [WIDTH:0]   add_sum;
  logic [WIDTH:0]   sh_rem;
  logic [WIDTH:0]   diff;
  logic [WIDTH-1:0] rem_n, quo_n;

  assign add_sum = {1'b0, rem_q} + (quo_q[0] ? {1'b0, opb_q} : '0);
  assign sh_rem  = {rem_q, quo_q[WIDTH-1]};
  // sh_rem < 2*divisor, so the difference always fits in WIDTH+1 signed bits
  assign diff    = sh_rem - {1'b0, opb_q};

  always_comb begin
    rem_n = rem_q;
    quo_n = quo_q;
    if (is_div_q) begin
      if (!diff[WIDTH]) begin
        rem_n = diff[WIDTH-1:0];
        quo_n = {quo_q[WIDTH-2:0], 1'b1};
      end else begin
        rem_n = sh_rem[WIDTH-1:0];
        quo_n = {quo_q[WIDTH-2:0], 1'b0};
      end
    end else begin
      rem_n = add_sum[WIDTH:1];
      quo_n = {add_sum[0], quo_q[WIDTH-1:1]};
    end
  end

  // Sign fix-up of the final step, applied as the result is committed
  logic [2*WIDTH-1:0] prod_raw, prod_fix;
  logic [WIDTH-1:0]   quo_fix, rem_fix;

  assign prod_raw = {rem_n, quo_n};
  assign prod_fix = neg_q  ? (~prod_raw + 1'b1) : prod_raw;
  assign quo_fix  = neg_q  ? (~quo_n + 1'b1)    : quo_n;
  assign rem_fix  = rneg_q ? (~rem_n + 1'b1)    : rem_n;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    rem_d    = rem_q;
    quo_d    = quo_q;
    opb_d    = opb_q;
    is_div_d = is_div_q;
    neg_d    = neg_q;
    rneg_d   = rneg_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    done_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (hi_we) hi_d = wdata;
        if (lo_we) lo_d = wdata;
        if (start && !flush) begin
          if (st_div && b_zero) begin
            // Divide by zero: fixed result, no iterations
            hi_d    = a;
            lo_d    = {WIDTH{1'b1}};
            done_d  = 1'b1;
            state_d = S_DONE;
          end else begin
            is_div_d = st_div;
            neg_d    = a_neg ^ b_neg;
            rneg_d   = a_neg;
            rem_d    = '0;
            quo_d    = st_div ? abs_a : abs_b;
            opb_d    = st_div ? abs_b : abs_a;
            cnt_d    = CNT_W'(WIDTH);
            state_d  = S_RUN;
          end
        end
      end
      S_RUN: begin
        if (flush) begin
          state_d = S_IDLE;
        end else begin
          rem_d = rem_n;
          quo_d = quo_n;
          cnt_d = cnt_q - 1'b1;
          if (cnt_q == CNT_W'(1)) begin
            if (is_div_q) begin
              hi_d = rem_fix;
              lo_d = quo_fix;
            end else begin
              hi_d = prod_fix[2*WIDTH-1:WIDTH];
              lo_d = prod_fix[WIDTH-1:0];
            end
            done_d  = 1'b1;
            state_d = S_DONE;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
      opb_q    <= '0;
      is_div_q <= 1'b0;
      neg_q    <= 1'b0;
      rneg_q   <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rem_q    <= rem_d;
      quo_q    <= quo_d;
      opb_q    <= opb_d;
      is_div_q <= is_div_d;
      neg_q    <= neg_d;
      rneg_q   <= rneg_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign hi        = hi_q;
  assign lo        = lo_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_muldiv_unit.sv
module tb_muldiv_unit;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [1:0]   op;
  logic [W-1:0] a, b;
  logic         flush;
  logic         hi_we, lo_we;
  logic [W-1:0] wdata;
  logic         busy, done;
  logic [W-1:0] hi, lo;
  logic [1:0]   state_dbg;

  int n_tests = 0;
  int n_fail  = 0;

  localparam logic [1:0] OP_MULT = 2'b00, OP_MULTU = 2'b01,
                         OP_DIV  = 2'b10, OP_DIVU  = 2'b11;

  muldiv_unit #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
    .flush(flush), .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata),
    .busy(busy), .done(done), .hi(hi), .lo(lo), .state_dbg(state_dbg)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Launches one op and follows it to completion. Inputs change and outputs
  // are sampled 1 time unit after each rising edge. k counts cycles after
  // the start cycle T, so done seen at k means done in cycle T+k.
  task automatic run_op(input string tag, input logic [1:0] o,
                        input logic [W-1:0] av, input logic [W-1:0] bv,
                        input logic [W-1:0] exp_hi, input logic [W-1:0] exp_lo,
                        input int exp_lat, input logic hw, input logic [W-1:0] wd,
                        input logic inject);
    int  k;
    bit  busy_ok;
    start = 1'b1; op = o; a = av; b = bv; hi_we = hw; wdata = wd;
    tick();
    start = 1'b0; hi_we = 1'b0;
    k = 1;
    busy_ok = 1'b1;
    if (hw) check({tag, "_mthi_now"}, hi, wd);
    while (!done && k < 100) begin
      if (!busy) busy_ok = 1'b0;
      if (inject && k == 5) begin
        start = 1'b1; op = OP_MULTU; a = 32'd100; b = 32'd100;
      end
      if (inject && k == 6) start = 1'b0;
      tick();
      k++;
    end
    start = 1'b0;
    if (!busy) busy_ok = 1'b0;
    check({tag, "_lat"}, k, exp_lat);
    check({tag, "_busy_run"}, busy_ok, 1'b1);
    check({tag, "_hi"}, hi, exp_hi);
    check({tag, "_lo"}, lo, exp_lo);
    tick();
    check({tag, "_done_after"}, done, 1'b0);
    check({tag, "_busy_after"}, busy, 1'b0);
  endtask

  initial begin
    int k;
    bit seen_done;
    rst = 1'b1; start = 1'b0; op = '0; a = '0; b = '0;
    flush = 1'b0; hi_we = 1'b0; lo_we = 1'b0; wdata = '0;
    #12;
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_hi", hi, '0);
    check("rst_lo", lo, '0);
    check("rst_state", state_dbg, 2'd0);
    @(negedge clk); rst = 1'b0;
    tick();

    // 1. unsigned full-scale product
    run_op("multu_ff", OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 33, 1'b0, '0, 1'b0);
    // 2. signed multiply / divide
    run_op("mult_m3x5", OP_MULT, 32'hFFFFFFFD, 32'h00000005, 32'hFFFFFFFF, 32'hFFFFFFF1, 33, 1'b0, '0, 1'b0);
    run_op("div_m7d2", OP_DIV, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 33, 1'b0, '0, 1'b0);
    run_op("div_7dm2", OP_DIV, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 33, 1'b0, '0, 1'b0);
    run_op("mult_m1xm1", OP_MULT, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001, 33, 1'b0, '0, 1'b0);
    run_op("divu_big", OP_DIVU, 32'hFFFFFFFF, 32'h00000010, 32'h0000000F, 32'h0FFFFFFF, 33, 1'b0, '0, 1'b0);
    // 3. divide by zero and overflow
    run_op("divu_by0", OP_DIVU, 32'h00000007, 32'h00000000, 32'h00000007, 32'hFFFFFFFF, 1, 1'b0, '0, 1'b0);
    run_op("div_ovf", OP_DIV, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 33, 1'b0, '0, 1'b0);

    // 4. mthi/mtlo, then flush a multiply at T+10
    hi_we = 1'b1; wdata = 32'h1234;
    tick();
    hi_we = 1'b0; lo_we = 1'b1; wdata = 32'h0;
    tick();
    lo_we = 1'b0;
    check("mthi_hi", hi, 32'h1234);
    check("mtlo_lo", lo, 32'h0);
    start = 1'b1; op = OP_MULT; a = 32'd3; b = 32'd4;
    tick();
    start = 1'b0;
    seen_done = 1'b0;
    for (k = 1; k < 10; k++) begin
      if (done) seen_done = 1'b1;
      tick();
    end
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("flush_busy", busy, 1'b0);
    for (int j = 0; j < 40; j++) begin
      if (done) seen_done = 1'b1;
      tick();
    end
    check("flush_no_done", seen_done, 1'b0);
    check("flush_hi", hi, 32'h1234);
    check("flush_lo", lo, 32'h0);

    // flush wins over start in IDLE
    start = 1'b1; flush = 1'b1; op = OP_MULTU; a = 32'd2; b = 32'd2;
    tick();
    start = 1'b0; flush = 1'b0;
    check("flush_start_busy", busy, 1'b0);
    check("flush_start_state", state_dbg, 2'd0);

    // 5. async reset mid-RUN
    start = 1'b1; op = OP_MULTU; a = 32'd5; b = 32'd5;
    tick();
    start = 1'b0;
    tick(); tick();
    check("pre_rst_busy", busy, 1'b1);
    #2 rst = 1'b1;
    #1;
    check("midrst_busy", busy, 1'b0);
    check("midrst_done", done, 1'b0);
    check("midrst_hi", hi, '0);
    check("midrst_lo", lo, '0);
    check("midrst_state", state_dbg, 2'd0);
    tick();
    rst = 1'b0;
    tick();
    run_op("mult_6x7", OP_MULTU, 32'd6, 32'd7, 32'h0, 32'h2A, 33, 1'b0, '0, 1'b0);

    // 6. mthi in the start cycle, start while busy ignored
    run_op("divu_9d2_hw", OP_DIVU, 32'd9, 32'd2, 32'h1, 32'h4, 33, 1'b1, 32'hAA, 1'b1);
    check("after_inject_state", state_dbg, 2'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
